// File: rtl/vp_pkg.sv
// vp_pkg: shared instruction, opcode and FSM types for the vector sequencer.
package vp_pkg;

    localparam logic [1:0] OP_SUM   = 2'd0;
    localparam logic [1:0] OP_MUL   = 2'd1;
    localparam logic [1:0] OP_LOAD  = 2'd2;
    localparam logic [1:0] OP_STORE = 2'd3;

    typedef struct packed {
        logic [1:0] opcode;
        logic [1:0] rg;
        logic [4:0] maddr;
    } instr_t;

    typedef enum logic {IDLE, ISSUE} state_t;

    // An instruction is legal only if every register it reads has been written.
    function automatic logic is_legal(instr_t i, logic [1:0] ld, logic res);
        return (i.opcode == OP_LOAD)  ? 1'b1 :
               (i.opcode == OP_STORE) ? (i.rg[1] ? res : ld[i.rg[0]]) :
               (ld == 2'b11);
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: synchronous FIFO with full/empty flags and a synchronous flush.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] cnt_q, cnt_d;
    logic do_push, do_pop;

    assign full    = cnt_q == (AW+1)'(DEPTH);
    assign empty   = cnt_q == '0;
    assign dout    = mem_q[rd_q];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wr_q] = din;
        wr_d  = flush ? '0 : wr_q + AW'(do_push);
        rd_d  = flush ? '0 : rd_q + AW'(do_pop);
        cnt_d = flush ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/vector_sequencer.sv
// vector_sequencer: buffers vector instructions, rejects reads of unwritten
// registers and presents each legal instruction to the processor for HOLD_CYCLES.
module vector_sequencer
    import vp_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [1:0] instr_opcode,
    input  logic [1:0] instr_reg,
    input  logic [4:0] instr_maddr,
    input  logic       flush,
    output logic       vp_valid,
    output logic [1:0] vp_opcode,
    output logic [1:0] vp_reg,
    output logic [4:0] vp_maddr,
    output logic       busy,
    output logic       err,
    output logic [7:0] retired
);
    localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;

    state_t state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    instr_t iss_q, iss_d, head;
    logic [1:0] ld_q, ld_d;
    logic res_q, res_d, err_q, err_d;
    logic [7:0] retired_q, retired_d;
    logic full, empty, pop;

    instr_fifo #(.DEPTH(DEPTH), .W($bits(instr_t))) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (instr_valid),
        .pop   (pop),
        .din   ({instr_opcode, instr_reg, instr_maddr}),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign instr_ready = !full;
    assign vp_valid    = state_q == ISSUE;
    assign vp_opcode   = iss_q.opcode;
    assign vp_reg      = iss_q.rg;
    assign vp_maddr    = iss_q.maddr;
    assign busy        = !empty || state_q != IDLE;
    assign err         = err_q;
    assign retired     = retired_q;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        iss_d     = iss_q;
        ld_d      = ld_q;
        res_d     = res_q;
        err_d     = err_q;
        retired_d = retired_q;
        pop       = 1'b0;
        if (flush) begin
            state_d = IDLE;
            ld_d    = 2'b00;
            res_d   = 1'b0;
            err_d   = 1'b0;
        end else if (state_q == IDLE) begin
            if (!empty) begin
                pop = 1'b1;
                if (is_legal(head, ld_q, res_q)) begin
                    state_d = ISSUE;
                    iss_d   = head;
                    hold_d  = HW'(HOLD_CYCLES - 1);
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (hold_q != '0) begin
            hold_d = hold_q - HW'(1);
        end else begin
            state_d   = IDLE;
            retired_d = retired_q + 8'd1;
            // SUM/MUL write reg 2/3; a LOAD into reg 2 or 3 clobbers that result.
            res_d = (iss_q.opcode == OP_SUM || iss_q.opcode == OP_MUL) ? 1'b1 :
                    (iss_q.opcode == OP_LOAD && iss_q.rg[1]) ? 1'b0 : res_q;
            ld_d  = ld_q | ((iss_q.opcode == OP_LOAD && !iss_q.rg[1]) ?
                            (2'b01 << iss_q.rg[0]) : 2'b00);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            iss_q     <= '0;
            ld_q      <= 2'b00;
            res_q     <= 1'b0;
            err_q     <= 1'b0;
            retired_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            iss_q     <= iss_d;
            ld_q      <= ld_d;
            res_q     <= res_d;
            err_q     <= err_d;
            retired_q <= retired_d;
        end
    end

endmodule

// File: tb/tb_vector_sequencer.sv
// tb_vector_sequencer: directed and random stimulus checked every cycle against
// a queue-based model of the sequencer.
module tb_vector_sequencer;
    localparam int DEPTH = 4;
    localparam int HOLD  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic instr_valid = 1'b0;
    logic flush = 1'b0;
    logic [1:0] instr_opcode = '0;
    logic [1:0] instr_reg = '0;
    logic [4:0] instr_maddr = '0;
    logic instr_ready, vp_valid, busy, err;
    logic [1:0] vp_opcode, vp_reg;
    logic [4:0] vp_maddr;
    logic [7:0] retired;

    int n_tests = 0;
    int n_fail = 0;

    vector_sequencer #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_opcode (instr_opcode),
        .instr_reg    (instr_reg),
        .instr_maddr  (instr_maddr),
        .flush        (flush),
        .vp_valid     (vp_valid),
        .vp_opcode    (vp_opcode),
        .vp_reg       (vp_reg),
        .vp_maddr     (vp_maddr),
        .busy         (busy),
        .err          (err),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: pending instructions, cycles left in the current issue, register-written flags.
    logic [8:0] q[$];
    logic [8:0] cur = '0;
    logic [8:0] x;
    int phase = 0;
    int ret_m = 0;
    bit ld0 = 0, ld1 = 0, res_m = 0, err_m = 0, acc = 0, take;

    function automatic bit legal_m(logic [8:0] i);
        case (i[8:7])
            2'd2:    return 1'b1;
            2'd3:    return i[6:5] == 2'd0 ? ld0 : i[6:5] == 2'd1 ? ld1 : res_m;
            default: return ld0 && ld1;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            cur = '0; phase = 0; ret_m = 0;
            ld0 = 0; ld1 = 0; res_m = 0; err_m = 0; acc = 0;
        end else begin
            acc = 0;
            if (flush) begin
                q.delete();
                phase = 0; ld0 = 0; ld1 = 0; res_m = 0; err_m = 0;
            end else begin
                take = instr_valid && q.size() < DEPTH;
                if (phase == 0) begin
                    if (q.size() > 0) begin
                        x = q.pop_front();
                        if (legal_m(x)) begin
                            cur = x;
                            phase = HOLD;
                        end else begin
                            err_m = 1;
                        end
                    end
                end else begin
                    phase--;
                    if (phase == 0) begin
                        ret_m = (ret_m + 1) % 256;
                        if (cur[8:7] == 2'd2 && cur[6:5] == 2'd0) ld0 = 1;
                        if (cur[8:7] == 2'd2 && cur[6:5] == 2'd1) ld1 = 1;
                        if (cur[8:7] == 2'd2 && cur[6]) res_m = 0;
                        if (cur[8:7] < 2'd2) res_m = 1;
                    end
                end
                if (take) begin
                    q.push_back({instr_opcode, instr_reg, instr_maddr});
                    acc = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("vp_valid", vp_valid, phase > 0);
            check("busy", busy, q.size() > 0 || phase > 0);
            check("instr_ready", instr_ready, q.size() < DEPTH);
            check("err", err, err_m);
            check("retired", retired, ret_m);
            check("vp_fields", {vp_opcode, vp_reg, vp_maddr}, cur);
        end
    end

    task automatic send(input logic [1:0] op, input logic [1:0] rg, input logic [4:0] ma);
        int k = 0;
        instr_valid = 1'b1;
        instr_opcode = op;
        instr_reg = rg;
        instr_maddr = ma;
        do begin
            @(negedge clk);
            k++;
        end while (!acc && k < 500);
        if (!acc) check("push_timeout", 0, 1);
        instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((q.size() > 0 || phase > 0) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("idle_timeout", k < 5000, 1);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_vp_valid", vp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", instr_ready, 1);
        check("rst_err", err, 0);
        check("rst_retired", retired, 0);
        check("rst_fields", {vp_opcode, vp_reg, vp_maddr}, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        rst = 1'b0;
        do_reset();

        // Basic legal sequence.
        send(2'd2, 2'd0, 5'd0);
        send(2'd2, 2'd1, 5'd1);
        send(2'd0, 2'd0, 5'd0);
        send(2'd3, 2'd2, 5'd31);
        send(2'd3, 2'd3, 5'd30);
        wait_idle();
        check("basic_retired", retired, 5);
        check("basic_err", err, 0);

        // Illegal reads are dropped, err sticks.
        do_reset();
        send(2'd1, 2'd0, 5'd0);
        send(2'd3, 2'd2, 5'd16);
        wait_idle();
        check("illegal_err", err, 1);
        check("illegal_retired", retired, 0);
        send(2'd2, 2'd0, 5'd2);
        send(2'd2, 2'd1, 5'd3);
        send(2'd1, 2'd0, 5'd0);
        send(2'd3, 2'd3, 5'd15);
        wait_idle();
        check("legal_after_err_retired", retired, 4);
        check("legal_after_err_err", err, 1);

        // Backpressure: six back-to-back offers.
        for (int i = 0; i < 6; i++) send(2'd2, 2'(i), 5'(i + 7));
        wait_idle();
        check("backpressure_retired", retired, 10);

        // Flush mid-issue with a full queue behind it.
        do_reset();
        send(2'd2, 2'd0, 5'd1);
        send(2'd2, 2'd1, 5'd2);
        send(2'd2, 2'd2, 5'd3);
        send(2'd2, 2'd3, 5'd4);
        for (int k = 0; k < 100 && phase != HOLD - 1; k++) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_vp_valid", vp_valid, 0);
        check("flush_busy", busy, 0);
        check("flush_err", err, 0);
        send(2'd0, 2'd0, 5'd0);
        wait_idle();
        check("flush_sum_dropped", err, 1);

        // Asynchronous reset inside an issue window.
        send(2'd2, 2'd0, 5'd9);
        for (int k = 0; k < 100 && phase == 0; k++) @(negedge clk);
        @(negedge clk);
        do_reset();

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            flush = $urandom_range(0, 49) == 0;
            instr_valid = $urandom_range(0, 2) != 0;
            instr_opcode = $urandom_range(0, 9) < 5 ? 2'd2 : 2'($urandom_range(0, 3));
            instr_reg = 2'($urandom_range(0, 3));
            instr_maddr = 5'($urandom_range(0, 31));
            @(negedge clk);
        end
        flush = 1'b0;
        instr_valid = 1'b0;
        wait_idle();

        // Counter wrap.
        do_reset();
        for (int i = 0; i < 255; i++) send(2'd2, 2'(i), 5'(i));
        wait_idle();
        check("wrap_255", retired, 255);
        send(2'd2, 2'd3, 5'd0);
        wait_idle();
        check("wrap_0", retired, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
